// File: rtl/battleship_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : battleship_pkg                                               |
// | Description : Shared types and constants for the battleship game blocks:   |
// |               computer-attacker state encoding, default board size, LFSR   |
// |               tap mask and seed, and a popcount helper.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package battleship_pkg;

   localparam int         DEF_BOARD_W   = 5;
   localparam int         DEF_BOARD_H   = 5;

   // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1 (register bits 7, 5, 4, 3).
   localparam logic [7:0] LFSR_TAPS     = 8'hB8;
   localparam logic [7:0] DEF_LFSR_SEED = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PICK     = 3'd1,
      ST_PROBE    = 3'd2,
      ST_FIRE     = 3'd3,
      ST_DONE     = 3'd4,
      ST_WAIT_LOW = 3'd5
   } pc_attacker_state_t;

   // Boards are at most 32 cells, so one fixed-width counter covers every size.
   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] cnt;
      cnt = '0;
      for (int i = 0; i < 32; i++) begin
         cnt = cnt + {5'd0, v[i]};
      end
      return cnt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_attacker_lfsr8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lfsr8                                                        |
// | Description : Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1).       |
// |               Maximal length, so a non-zero seed never reaches zero.       |
// |               Shared by the attacker and random-placement logic.           |
// | Ports       : i_clk   - clock                                              |
// |               i_rst_n - asynchronous active-low reset (loads SEED)         |
// |               o_q     - current LFSR state                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lfsr8
   import battleship_pkg::*;
#(
   parameter logic [7:0] SEED = DEF_LFSR_SEED
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   output logic [7:0] o_q
);

   logic [7:0] r_q;
   logic       w_fb;

   assign w_fb = ^(r_q & LFSR_TAPS);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= SEED;
      end else begin
         r_q <= {r_q[6:0], w_fb};
      end
   end

   assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/pc_attacker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_attacker                                                  |
// | Description : Computer-opponent shot generator. On each pc_turn assertion  |
// |               picks an unshot cell (LFSR candidate, linear probe with      |
// |               wrap), fires one shot, updates shot/hit maps and counts down |
// |               the remaining player ship cells.                             |
// | Config      : PC_ATTACKER_HUNT_EN - after a hit, the next turn starts its  |
// |               search at the cell following the hit instead of the LFSR.    |
// | Ports       : i_clk, i_rst_n   - clock, asynchronous active-low reset      |
// |               i_load           - pulse: latch ship count, clear maps       |
// |               i_pc_turn        - level: request one shot                   |
// |               i_player_board   - occupancy, bit i = cell i                 |
// |               o_shot_valid     - pulse: shot fired this cycle              |
// |               o_shot_idx       - current/last shot cell                    |
// |               o_shot_hit       - shot cell occupied (with o_shot_valid)    |
// |               o_shot_map       - cells already fired on                    |
// |               o_hit_map        - cells fired on and occupied               |
// |               o_ships_left     - remaining unhit occupied cells            |
// |               o_turn_done      - pulse: turn finished                      |
// |               o_all_shot       - level: every cell fired on                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pc_attacker
   import battleship_pkg::*;
#(
   parameter  int         BOARD_W   = DEF_BOARD_W,
   parameter  int         BOARD_H   = DEF_BOARD_H,
   parameter  logic [7:0] LFSR_SEED = DEF_LFSR_SEED,
   localparam int         c_N       = BOARD_W * BOARD_H,
   localparam int         c_IDX_W   = (c_N > 1) ? $clog2(c_N) : 1,
   localparam int         c_CNT_W   = $clog2(c_N + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_load,
   input  logic               i_pc_turn,
   input  logic [c_N-1:0]     i_player_board,
   output logic               o_shot_valid,
   output logic [c_IDX_W-1:0] o_shot_idx,
   output logic               o_shot_hit,
   output logic [c_N-1:0]     o_shot_map,
   output logic [c_N-1:0]     o_hit_map,
   output logic [c_CNT_W-1:0] o_ships_left,
   output logic               o_turn_done,
   output logic               o_all_shot
);

   localparam logic [c_IDX_W-1:0] c_LAST    = c_IDX_W'(c_N - 1);
   localparam logic [c_IDX_W:0]   c_N_EXT   = (c_IDX_W + 1)'(c_N);
   localparam logic [c_CNT_W-1:0] c_N_PROBE = c_CNT_W'(c_N);

   function automatic logic [c_IDX_W-1:0] wrap_inc(input logic [c_IDX_W-1:0] v);
      return (v == c_LAST) ? '0 : v + c_IDX_W'(1);
   endfunction

   pc_attacker_state_t   r_state;
   logic [c_IDX_W-1:0]   r_cand;
   logic [c_CNT_W-1:0]   r_probe;
   logic                 r_shot_valid;
   logic [c_IDX_W-1:0]   r_shot_idx;
   logic                 r_shot_hit;
   logic [c_N-1:0]       r_shot_map;
   logic [c_N-1:0]       r_hit_map;
   logic [c_CNT_W-1:0]   r_ships_left;
   logic                 r_turn_done;
   logic                 r_all_shot;

   logic [7:0]           w_lfsr;
   logic [c_IDX_W:0]     w_raw_ext;
   logic [c_IDX_W:0]     w_raw_sub;
   logic [c_IDX_W-1:0]   w_lfsr_cand;
   logic [c_IDX_W-1:0]   w_pick;
   logic                 w_unused_bits;

   lfsr8 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .o_q     (w_lfsr)
   );

   // Low LFSR bits span [0, 2^IDX_W) and 2^IDX_W < 2N, so one conditional
   // subtraction folds the candidate into [0, N).
   assign w_raw_ext     = {1'b0, w_lfsr[c_IDX_W-1:0]};
   assign w_raw_sub     = w_raw_ext - c_N_EXT;
   assign w_lfsr_cand   = (w_raw_ext >= c_N_EXT) ? w_raw_sub[c_IDX_W-1:0]
                                                 : w_raw_ext[c_IDX_W-1:0];
   assign w_unused_bits = ^{w_lfsr[7:c_IDX_W], w_raw_sub[c_IDX_W]};

`ifdef PC_ATTACKER_HUNT_EN
   logic               r_hunt;
   logic [c_IDX_W-1:0] r_hunt_idx;

   assign w_pick = r_hunt ? wrap_inc(r_hunt_idx) : w_lfsr_cand;
`else
   assign w_pick = w_lfsr_cand;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_cand       <= '0;
         r_probe      <= '0;
         r_shot_valid <= 1'b0;
         r_shot_idx   <= '0;
         r_shot_hit   <= 1'b0;
         r_shot_map   <= '0;
         r_hit_map    <= '0;
         r_ships_left <= '0;
         r_turn_done  <= 1'b0;
         r_all_shot   <= 1'b0;
`ifdef PC_ATTACKER_HUNT_EN
         r_hunt       <= 1'b0;
         r_hunt_idx   <= '0;
`endif
      end else if (i_load) begin
         // A new board aborts any turn silently; park in WAIT_LOW if the
         // request is still up so the aborted request cannot fire later.
         r_state      <= i_pc_turn ? ST_WAIT_LOW : ST_IDLE;
         r_shot_valid <= 1'b0;
         r_turn_done  <= 1'b0;
         r_shot_map   <= '0;
         r_hit_map    <= '0;
         r_all_shot   <= 1'b0;
         r_ships_left <= c_CNT_W'(popcount32(32'(i_player_board)));
`ifdef PC_ATTACKER_HUNT_EN
         r_hunt       <= 1'b0;
`endif
      end else begin
         r_shot_valid <= 1'b0;
         r_turn_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_pc_turn) begin
                  r_state <= ST_PICK;
               end
            end
            ST_PICK: begin
               r_cand  <= w_pick;
               r_probe <= '0;
               r_state <= ST_PROBE;
            end
            ST_PROBE: begin
               // N failed probes means the start cell came round again.
               if (r_probe == c_N_PROBE) begin
                  r_all_shot  <= 1'b1;
                  r_turn_done <= 1'b1;
                  r_state     <= ST_DONE;
               end else if (!r_shot_map[r_cand]) begin
                  r_shot_valid <= 1'b1;
                  r_shot_idx   <= r_cand;
                  r_shot_hit   <= i_player_board[r_cand];
                  r_state      <= ST_FIRE;
               end else begin
                  r_cand  <= wrap_inc(r_cand);
                  r_probe <= r_probe + c_CNT_W'(1);
               end
            end
            ST_FIRE: begin
               r_shot_map[r_shot_idx] <= 1'b1;
               if (r_shot_hit) begin
                  r_hit_map[r_shot_idx] <= 1'b1;
                  if (r_ships_left != '0) begin
                     r_ships_left <= r_ships_left - c_CNT_W'(1);
                  end
               end
`ifdef PC_ATTACKER_HUNT_EN
               r_hunt     <= r_shot_hit;
               r_hunt_idx <= r_shot_idx;
`endif
               r_turn_done <= 1'b1;
               r_state     <= ST_DONE;
            end
            ST_DONE: begin
               r_state <= i_pc_turn ? ST_WAIT_LOW : ST_IDLE;
            end
            ST_WAIT_LOW: begin
               if (!i_pc_turn) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_shot_valid = r_shot_valid;
   assign o_shot_idx   = r_shot_idx;
   assign o_shot_hit   = r_shot_hit;
   assign o_shot_map   = r_shot_map;
   assign o_hit_map    = r_hit_map;
   assign o_ships_left = r_ships_left;
   assign o_turn_done  = r_turn_done;
   assign o_all_shot   = r_all_shot;

endmodule
`default_nettype wire

// File: tb/tb_pc_attacker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pc_attacker                                               |
// | Description : Self-checking bench for pc_attacker on a 5x5 board. A        |
// |               behavioural game model (cell sets, counts, LFSR sequence)    |
// |               predicts each shot, its timing and the resulting maps.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pc_attacker;

   localparam int         N     = 25;
   localparam int         IDX_W = 5;
   localparam int         CNT_W = 5;
   localparam logic [7:0] SEED  = 8'hA5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             load = 1'b0;
   logic             pc_turn = 1'b0;
   logic [N-1:0]     board = '0;
   logic             shot_valid;
   logic [IDX_W-1:0] shot_idx;
   logic             shot_hit;
   logic [N-1:0]     shot_map;
   logic [N-1:0]     hit_map;
   logic [CNT_W-1:0] ships_left;
   logic             turn_done;
   logic             all_shot;

   pc_attacker #(
      .BOARD_W   (5),
      .BOARD_H   (5),
      .LFSR_SEED (SEED)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_load         (load),
      .i_pc_turn      (pc_turn),
      .i_player_board (board),
      .o_shot_valid   (shot_valid),
      .o_shot_idx     (shot_idx),
      .o_shot_hit     (shot_hit),
      .o_shot_map     (shot_map),
      .o_hit_map      (hit_map),
      .o_ships_left   (ships_left),
      .o_turn_done    (turn_done),
      .o_all_shot     (all_shot)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Game model
   logic [7:0]   m_lfsr = SEED;
   logic [N-1:0] m_shot = '0;
   logic [N-1:0] m_hit  = '0;
   int           m_ships = 0;
   logic         m_all  = 1'b0;
   logic         m_hunt = 1'b0;
   int           m_hunt_idx = 0;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   function automatic int lfsr_cand(input logic [7:0] v);
      int r;
      r = int'(v) % 32;
      if (r >= N) r = r - N;
      return r;
   endfunction

   function automatic logic [N-1:0] rand_board(input int k, input logic [N-1:0] allowed,
                                               input logic [N-1:0] forced);
      logic [N-1:0] b;
      int           i;
      b = forced;
      while ($countones(b) < k) begin
         i = int'($urandom_range(0, N - 1));
         if (allowed[i]) b[i] = 1'b1;
      end
      return b;
   endfunction

   task automatic tick;
      @(posedge clk);
      if (rst_n) m_lfsr = lfsr_next(m_lfsr);
      #1;
   endtask

   task automatic model_reset;
      m_lfsr  = SEED;
      m_shot  = '0;
      m_hit   = '0;
      m_ships = 0;
      m_all   = 1'b0;
      m_hunt  = 1'b0;
   endtask

   task automatic do_load(input logic [N-1:0] b);
      board = b;
      load  = 1'b1;
      tick;
      load  = 1'b0;
      m_shot  = '0;
      m_hit   = '0;
      m_all   = 1'b0;
      m_hunt  = 1'b0;
      m_ships = $countones(b);
      n_checks++;
      if (ships_left !== CNT_W'(m_ships) || shot_map !== '0 || hit_map !== '0 || all_shot !== 1'b0) begin
         n_fail++;
         $display("FAIL load_state: ships=%0d shot_map=%h hit_map=%h all_shot=%b required ships=%0d maps=0 all_shot=0",
                  ships_left, shot_map, hit_map, all_shot, m_ships);
      end
   endtask

   // Wait in IDLE until the next turn's LFSR candidate equals t.
   task automatic aim(input int t);
      int guard;
      guard = 0;
      while (lfsr_cand(lfsr_next(m_lfsr)) != t && guard < 300) begin
         tick;
         guard++;
      end
      n_checks++;
      if (guard >= 300) begin
         n_fail++;
         $display("FAIL aim_timeout: candidate %0d never came up", t);
      end
   endtask

   // One full turn: raise pc_turn, predict and check the outcome.
   task automatic do_turn(input int drop_at, input int hold, output int got_idx);
      int   cand, exp_k, exp_cell, exp_done;
      int   sv_cnt, sv_cyc, done_cyc, idx_seen, extra;
      logic hit_seen, exp_hit;
      sv_cnt = 0; sv_cyc = -1; done_cyc = -1; idx_seen = -1; hit_seen = 1'b0;
      exp_cell = -1; exp_k = 0; extra = 0;
      pc_turn = 1'b1;
      tick;                                   // edge 0 -> cycle 1
      cand = lfsr_cand(m_lfsr);
`ifdef PC_ATTACKER_HUNT_EN
      if (m_hunt) cand = (m_hunt_idx + 1) % N;
`endif
      for (int k = 0; k < N; k++) begin
         if (!m_shot[(cand + k) % N]) begin
            exp_cell = (cand + k) % N;
            exp_k    = k;
            break;
         end
      end
      for (int cyc = 2; cyc <= N + 10; cyc++) begin
         tick;
         if (shot_valid === 1'b1) begin
            sv_cnt++;
            sv_cyc   = cyc;
            idx_seen = int'(shot_idx);
            hit_seen = shot_hit;
         end
         if (turn_done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         if (cyc == drop_at) pc_turn = 1'b0;
      end
      if (exp_cell >= 0) begin
         exp_hit = board[exp_cell];
         exp_done = 4 + exp_k;
         m_shot[exp_cell] = 1'b1;
         if (exp_hit) begin
            m_hit[exp_cell] = 1'b1;
            if (m_ships > 0) m_ships--;
            m_hunt_idx = exp_cell;
         end
         m_hunt = exp_hit;
         n_checks++;
         if (sv_cnt != 1 || sv_cyc != 3 + exp_k) begin
            n_fail++;
            $display("FAIL shot_timing: got %0d pulses at cycle %0d required 1 at cycle %0d", sv_cnt, sv_cyc, 3 + exp_k);
         end
         n_checks++;
         if (idx_seen != exp_cell || hit_seen !== exp_hit) begin
            n_fail++;
            $display("FAIL shot_cell: got idx=%0d hit=%b required idx=%0d hit=%b", idx_seen, hit_seen, exp_cell, exp_hit);
         end
      end else begin
         exp_done = N + 3;
         m_all = 1'b1;
         n_checks++;
         if (sv_cnt != 0) begin
            n_fail++;
            $display("FAIL all_shot_no_fire: got %0d shot pulses required 0", sv_cnt);
         end
      end
      n_checks++;
      if (done_cyc != exp_done) begin
         n_fail++;
         $display("FAIL turn_done_cycle: got %0d required %0d", done_cyc, exp_done);
      end
      n_checks++;
      if (shot_map !== m_shot || hit_map !== m_hit || ships_left !== CNT_W'(m_ships) || all_shot !== m_all) begin
         n_fail++;
         $display("FAIL turn_state: shot_map=%h hit_map=%h ships=%0d all=%b required %h %h %0d %b",
                  shot_map, hit_map, ships_left, all_shot, m_shot, m_hit, m_ships, m_all);
      end
      for (int i = 0; i < hold; i++) begin
         tick;
         if (shot_valid === 1'b1 || turn_done === 1'b1) extra++;
      end
      if (hold > 0) begin
         n_checks++;
         if (extra != 0) begin
            n_fail++;
            $display("FAIL one_shot_per_turn: got %0d extra pulses while pc_turn held, required 0", extra);
         end
      end
      pc_turn = 1'b0;
      tick;
      got_idx = idx_seen;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) tick;
      n_checks++;
      if ({shot_valid, shot_idx, shot_hit, shot_map, hit_map, ships_left, turn_done, all_shot} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0",
                  {shot_valid, shot_idx, shot_hit, shot_map, hit_map, ships_left, turn_done, all_shot});
      end
      model_reset;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_load;
      do_load(rand_board(7, '1, '0));
      n_checks++;
      if (ships_left !== CNT_W'(7) || shot_valid !== 1'b0 || turn_done !== 1'b0) begin
         n_fail++;
         $display("FAIL load_seven: got ships=%0d sv=%b done=%b required 7 0 0", ships_left, shot_valid, turn_done);
      end
   endtask

   task automatic test_single_shot;
      int idx;
      do_turn(0, 6, idx);
      n_checks++;
      if ($countones(shot_map) != 1) begin
         n_fail++;
         $display("FAIL single_shot_bits: got %0d map bits required 1", $countones(shot_map));
      end
      do_turn(0, 0, idx);
   endtask

   task automatic test_full_game;
      int idx;
      do_load(rand_board(7, '1, '0));
      for (int t = 0; t < N; t++) begin
         repeat ($urandom_range(0, 4)) tick;
         do_turn(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), idx);
      end
      n_checks++;
      if (shot_map !== {N{1'b1}} || ships_left !== '0 || hit_map !== board) begin
         n_fail++;
         $display("FAIL full_game: shot_map=%h ships=%0d hit_map=%h required all ones, 0, %h",
                  shot_map, ships_left, hit_map, board);
      end
      do_turn(0, 2, idx);                     // 26th turn: nothing left
   endtask

   task automatic test_wrap;
      int idx;
      do_load(rand_board(7, 25'h00F_FFFF, '0));
      for (int t = 20; t <= 24; t++) begin
         aim(t);
         do_turn(0, 0, idx);
      end
      aim(22);
      do_turn(0, 0, idx);
      n_checks++;
      if (idx != 0) begin
         n_fail++;
         $display("FAIL wrap_cell: got %0d required 0", idx);
      end
   endtask

   task automatic test_abort_load;
      int           idx, extra;
      logic [N-1:0] nb;
      do_load(rand_board(7, '1, '0));
      do_turn(0, 0, idx);
      do_turn(0, 0, idx);
      nb = rand_board(int'($urandom_range(3, 12)), '1, '0);
      pc_turn = 1'b1;
      tick;                                   // cycle 1: PICK
      tick;                                   // cycle 2: PROBE
      board = nb;
      load  = 1'b1;
      tick;
      load  = 1'b0;
      m_shot = '0; m_hit = '0; m_all = 1'b0; m_hunt = 1'b0; m_ships = $countones(nb);
      extra = (shot_valid === 1'b1) ? 1 : 0;
      repeat (6) begin
         tick;
         if (shot_valid === 1'b1 || turn_done === 1'b1) extra++;
      end
      n_checks++;
      if (extra != 0) begin
         n_fail++;
         $display("FAIL abort_load_pulses: got %0d pulses required 0", extra);
      end
      n_checks++;
      if (shot_map !== '0 || hit_map !== '0 || ships_left !== CNT_W'(m_ships)) begin
         n_fail++;
         $display("FAIL abort_load_state: maps=%h/%h ships=%0d required 0/0 %0d", shot_map, hit_map, ships_left, m_ships);
      end
      pc_turn = 1'b0;
      tick;
      do_turn(0, 0, idx);                     // turn after abort behaves normally
   endtask

   task automatic test_abort_reset;
      int   idx;
      logic found;
      do_load(rand_board(7, '1, '0));
      found = 1'b0;
      pc_turn = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (shot_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL reset_fire_reach: got no shot_valid in 40 cycles, required one");
      end
      rst_n = 1'b0;
      model_reset;
      #1;
      n_checks++;
      if ({shot_valid, shot_idx, shot_hit, shot_map, hit_map, ships_left, turn_done, all_shot} !== '0) begin
         n_fail++;
         $display("FAIL reset_in_fire: got %h required 0",
                  {shot_valid, shot_idx, shot_hit, shot_map, hit_map, ships_left, turn_done, all_shot});
      end
      tick;
      n_checks++;
      if ({shot_valid, shot_map, hit_map, ships_left, turn_done} !== '0) begin
         n_fail++;
         $display("FAIL reset_hold: got %h required 0", {shot_valid, shot_map, hit_map, ships_left, turn_done});
      end
      pc_turn = 1'b0;
      rst_n = 1'b1;
      tick;
      do_load(rand_board(7, '1, '0));
      do_turn(0, 0, idx);                     // LFSR restarts from the seed
   endtask

   task automatic test_hunt;
      int idx;
      do_load(rand_board(7, ~25'h000_2000, 25'h000_1000));
      aim(12);
      do_turn(0, 0, idx);
      n_checks++;
      if (idx != 12 || hit_map[12] !== 1'b1) begin
         n_fail++;
         $display("FAIL hunt_first_hit: got idx=%0d hit=%b required 12 1", idx, hit_map[12]);
      end
      repeat ($urandom_range(0, 5)) tick;
      do_turn(0, 0, idx);
`ifdef PC_ATTACKER_HUNT_EN
      n_checks++;
      if (idx != 13) begin
         n_fail++;
         $display("FAIL hunt_follow: got %0d required 13", idx);
      end
`endif
   endtask

   initial begin
      test_reset;
      test_load;
      test_single_shot;
      test_full_game;
      test_wrap;
      test_abort_load;
      test_abort_reset;
      test_hunt;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
